// File: rtl/timing_pkg.sv
// timing_pkg: shared constants and width helper for the timing generator.
package timing_pkg;
  localparam int NUM_T_DEFAULT = 16;
  localparam bit WRAP = 1'b1;
  localparam bit HALT = 1'b0;
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < n) w = i + 1;
    return w;
  endfunction
endpackage

// File: rtl/tg_decoder.sv
// tg_decoder: binary state index to one-hot timing signal decode.
module tg_decoder #(
  parameter int CW = 4,
  parameter int N  = 16
) (
  input  logic [CW-1:0] idx,
  output logic [N-1:0]  onehot
);
  assign onehot = N'(1) << idx;
endmodule

// File: rtl/timing_generator.sv
// timing_generator: control-unit sequence counter with one-hot timing outputs.
module timing_generator
  import timing_pkg::*;
#(
  parameter int NUM_T     = NUM_T_DEFAULT,
  parameter bit WRAP_MODE = WRAP,
  localparam int CW       = clog2_min1(NUM_T)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          en,
  output logic [NUM_T-1:0] t,
  output logic [CW-1:0] count,
  output logic          last,
  output logic          wrap,
  output logic          halted,
  output logic          ld_err
);
  localparam logic [CW-1:0] LAST  = CW'(NUM_T - 1);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(NUM_T);
  logic [CW-1:0] count_q, count_d;
  logic halted_q, halted_d, wrap_q, wrap_d, ld_err_q, ld_err_d;
  always_comb begin
    count_d  = count_q;
    halted_d = halted_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (clr) begin
      count_d  = '0;
      halted_d = 1'b0;
    end else if (ld) begin
      // out-of-range loads are dropped so the counter never leaves 0..NUM_T-1
      if ({1'b0, ld_val} < LIMIT) begin
        count_d  = ld_val;
        halted_d = 1'b0;
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (en) begin
      if (count_q != LAST) count_d = count_q + CW'(1);
      else if (WRAP_MODE) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else halted_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q  <= '0;
      halted_q <= 1'b0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      halted_q <= halted_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end
  tg_decoder #(.CW(CW), .N(NUM_T)) u_dec (.idx(count_q), .onehot(t));
  assign count  = count_q;
  assign last   = count_q == LAST;
  assign wrap   = wrap_q;
  assign halted = halted_q;
  assign ld_err = ld_err_q;
endmodule
